inst_fetch_queue: RTL and testbench

Instruction fetch front end that consumes the fetch-address stream produced by the program counter, issues in-order read requests to instruction memory, pairs each returned word with its address and buffers the pairs for the decode stage. Sits between the PC and decode. Owns the redirect flush: on a taken jump it drops buffered instructions and every response still in flight.

---
 rtl/inst_fetch_queue.sv | 115 +++++++++++
 tb/tb_inst_fetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues in-order reads for PC addresses, pairs each
// returned word with its address and buffers the pairs for decode; flush drops all.
module inst_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        fetch_addr,
  input  logic                     fetch_valid,
  output logic                     fetch_ready,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [INST_W-1:0]        mem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [INST_W-1:0]        inst_data,
  output logic [ADDR_W-1:0]        inst_addr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [INST_W-1:0] fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] pend_addr_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] prd_ptr_q, prd_ptr_d, pwr_ptr_q, pwr_ptr_d;
  logic [CW-1:0] occ_q, occ_d, out_q, out_d, disc_q, disc_d;
  logic          grant, rsp, drop, push, pop;

  // Credit rule: FIFO entries plus requests in flight never exceed DEPTH, so
  // neither queue can overflow however long decode stalls.
  assign mem_req     = rst & fetch_valid & ~flush
                     & (({1'b0, occ_q} + {1'b0, out_q}) < CREDITS);
  assign grant       = mem_req & mem_gnt;
  assign fetch_ready = grant;
  assign mem_addr    = fetch_addr;

  // A response with nothing outstanding is a protocol violation and is ignored.
  assign rsp  = mem_rvalid & (out_q != '0);
  assign drop = disc_q != '0;
  assign push = rsp & ~drop & ~flush;
  assign pop  = inst_valid & inst_ready & ~flush;

  assign inst_valid = occ_q != '0;
  assign inst_addr  = fifo_addr_q[rd_ptr_q];
  assign inst_data  = fifo_data_q[rd_ptr_q];
  assign occupancy  = occ_q;

  always_comb begin
    // NOTE: every _d is assigned on every path, so no latch can be inferred.
    pwr_ptr_d = pwr_ptr_q + PW'(grant);
    prd_ptr_d = prd_ptr_q + PW'(rsp);
    out_d     = out_q + CW'(grant) - CW'(rsp);
    wr_ptr_d  = wr_ptr_q + PW'(push);
    if (flush) begin
      occ_d    = '0;
      rd_ptr_d = wr_ptr_q;
      disc_d   = out_q - CW'(rsp);
    end else begin
      occ_d    = occ_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      disc_d   = disc_q - CW'(rsp & drop);
    end
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      prd_ptr_q <= '0;
      pwr_ptr_q <= '0;
      occ_q     <= '0;
      out_q     <= '0;
      disc_q    <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      prd_ptr_q <= prd_ptr_d;
      pwr_ptr_q <= pwr_ptr_d;
      occ_q     <= occ_d;
      out_q     <= out_d;
      disc_q    <= disc_d;
    end
  end

  // NOTE: the FIFO storage is reset because it drives inst_addr/inst_data
  // directly; the pending queue is not, as an entry is only read after a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else if (push) begin
      fifo_addr_q[wr_ptr_q] <= pend_addr_q[prd_ptr_q];
      fifo_data_q[wr_ptr_q] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) pend_addr_q[pwr_ptr_q] <= fetch_addr;
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: directed fetch streams against a memory
// model; a monitor pops expected {addr,data} pairs whenever decode consumes one.
module tb_inst_fetch_queue;

  logic        clk, rst, fetch_valid, flush, mem_gnt, mem_rvalid, inst_ready;
  logic [31:0] fetch_addr, mem_rdata, mem_addr, inst_data, inst_addr;
  logic        fetch_ready, mem_req, inst_valid;
  logic [2:0]  occupancy;

  inst_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_addr(inst_addr), .occupancy(occupancy)
  );

  typedef struct { logic [31:0] addr; int unsigned ready; } pend_t;

  pend_t       mem_q[$];
  logic [31:0] issue_q[$];
  logic [31:0] exp_q[$];

  int          n_vec = 0, n_miss = 0;
  int unsigned cyc = 0, last_ready = 0;
  int          lat_min = 1, lat_max = 1, gnt_stall = 0;
  bit          stray = 0, gnt_flag = 0;
  logic [31:0] gnt_addr = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memdata(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model and PC driver: inputs change 1 time unit after posedge, grants
  // are observed at negedge and answered in order after a chosen latency.
  initial begin
    fetch_valid = 0; fetch_addr = '0; mem_gnt = 1; mem_rvalid = 0; mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) begin
        mem_q.delete();
        last_ready = 0;
        mem_rvalid = 0;
      end else if (mem_q.size() != 0 && mem_q[0].ready <= cyc) begin
        pend_t p;
        p = mem_q.pop_front();
        mem_rvalid = 1;
        mem_rdata  = memdata(p.addr);
      end else if (stray) begin
        mem_rvalid = 1;
        mem_rdata  = 32'hDEAD_BEEF;
        stray      = 0;
      end else begin
        mem_rvalid = 0;
      end
      fetch_valid = issue_q.size() != 0;
      if (fetch_valid) fetch_addr = issue_q[0];
      mem_gnt = (gnt_stall == 0) ? 1'b1 : ($urandom_range(0, gnt_stall) == 0);
      @(negedge clk);
      gnt_flag = mem_req & mem_gnt;
      gnt_addr = mem_addr;
      if (gnt_flag) begin
        int unsigned r;
        r = cyc + $urandom_range(lat_min, lat_max);
        if (r <= last_ready) r = last_ready + 1;
        last_ready = r;
        mem_q.push_back('{mem_addr, r});
        void'(issue_q.pop_front());
      end
    end
  end

  // Monitor: every instruction consumed by decode must be the next expected pair.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && inst_valid && inst_ready && !flush) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_inst: got addr %h data %h, expected nothing", inst_addr, inst_data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("inst_pair", {inst_addr, inst_data}, {e, memdata(e)});
        end
      end
    end
  end

  task automatic wait_grant_of(input logic [31:0] a, input int budget);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge clk); #2;
      hit = gnt_flag && (gnt_addr == a);
    end
    if (!hit) begin
      n_vec++;
      n_miss++;
      $display("FAIL grant_timeout: no grant of %h within %0d cycles", a, budget);
    end
  endtask

  task automatic drain(input string name, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && (mem_q.size() == 0) && (issue_q.size() == 0) && !inst_valid;
    end
    check({"drain_", name}, 64'(done), 64'd1);
    @(posedge clk); #2;
  endtask

  task automatic issue(input logic [31:0] base, input int n, input bit expect_it);
    for (int i = 0; i < n; i++) begin
      issue_q.push_back(base + 32'(4 * i));
      if (expect_it) exp_q.push_back(base + 32'(4 * i));
    end
  endtask

  initial begin
    rst = 0; flush = 0; inst_ready = 1;
    issue(32'h0, 16, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_head", {inst_addr, inst_data}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_fetch_ready", {63'd0, fetch_ready}, 64'd0);

    // Streaming: first instruction two cycles after its grant, then one per cycle.
    @(posedge clk); #2; rst = 1;
    wait_grant_of(32'h0, 5);
    @(negedge clk);
    check("stream_latency_min", 64'(inst_valid), 64'd0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("stream_rate", {31'd0, inst_valid, inst_addr}, {31'd0, 1'b1, 32'(4 * i)});
    end
    drain("stream", 40);

    // Backpressure: decode stalled, four grants fill the FIFO and requests stop.
    inst_ready = 0;
    issue(32'h0, 8, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("bp_occupancy", 64'(occupancy), 64'd4);
    check("bp_mem_req", {62'd0, fetch_valid, mem_req}, {62'd0, 2'b10});
    check("bp_head", {inst_addr, inst_data}, {32'h0, memdata(32'h0)});
    @(posedge clk); #2; inst_ready = 1;
    drain("backpressure", 60);

    // Flush with three requests in flight: all three responses are discarded.
    lat_min = 4; lat_max = 4;
    issue(32'h10, 3, 0);
    wait_grant_of(32'h18, 20);
    flush = 1;
    issue(32'h100, 1, 1);
    @(posedge clk); #2; flush = 0;
    @(negedge clk);
    check("flush_f1_valid_req", {62'd0, inst_valid, mem_req}, {62'd0, 2'b01});
    drain("flush_inflight", 60);

    // Flush coinciding with the response for 0x20 while two are outstanding.
    lat_min = 2; lat_max = 2;
    issue(32'h20, 2, 0);
    wait_grant_of(32'h24, 20);
    flush = 1;
    issue(32'h200, 1, 1);
    @(posedge clk); #2; flush = 0;
    drain("flush_same_cycle", 40);

    // Flush with a full FIFO while decode is ready: flush wins, nothing pops.
    lat_min = 1; lat_max = 1;
    inst_ready = 0;
    issue(32'h700, 4, 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("full_before_flush", 64'(occupancy), 64'd4);
    @(posedge clk); #2; flush = 1; inst_ready = 1;
    @(posedge clk); #2; flush = 0;
    @(negedge clk);
    check("flush_full_cleared", {61'd0, inst_valid, occupancy}, 64'd0);
    drain("flush_full", 10);

    // Response with nothing outstanding must not change any state.
    stray = 1;
    repeat (3) @(negedge clk);
    check("stray_ignored", {61'd0, inst_valid, occupancy}, 64'd0);
    @(posedge clk); #2;
    issue(32'h800, 2, 1);
    drain("after_stray", 20);

    // Variable grant stalls, memory latency and decode readiness.
    lat_min = 1; lat_max = 4; gnt_stall = 3;
    issue(32'h400, 24, 1);
    for (int c = 0; c < 400 && exp_q.size() != 0; c++) begin
      @(posedge clk); #2;
      inst_ready = ($urandom_range(0, 3) != 0);
    end
    inst_ready = 1; gnt_stall = 0; lat_min = 1; lat_max = 1;
    drain("random", 100);

    // Asynchronous reset mid-burst with three buffered and one in flight.
    inst_ready = 0;
    issue(32'h500, 5, 0);
    wait_grant_of(32'h50C, 20);
    @(negedge clk);
    check("pre_reset_occupancy", 64'(occupancy), 64'd3);
    #1 rst = 0;
    #1;
    check("async_reset_outputs", {60'd0, inst_valid, occupancy}, 64'd0);
    check("async_reset_mem_req", {62'd0, mem_req, fetch_ready}, 64'd0);
    issue_q.delete();
    issue(32'h600, 2, 1);
    inst_ready = 1;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    drain("after_reset", 30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
